// File: rtl/mul_rr_sched.sv
// Round-robin arbiter feeding one shared 4x4 unsigned multiplier through a
// two-stage pipeline (S1 operands, S2 result) with valid/ready handshakes.
module mul_rr_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  output logic [7:0]        res_product,
  output logic [IDW-1:0]    res_id,
  input  logic              res_ready,
  output logic [7:0]        op_count
);

  localparam int unsigned OPW = 4;
  localparam int unsigned PW  = 2 * OPW;

  if (NREQ < 2 || NREQ > 4 || IDW != $clog2(NREQ)) begin : g_param_check
    $error("mul_rr_sched: NREQ must be 2..4 and IDW must equal clog2(NREQ)");
  end

  logic           adv;
  logic           grant_any;
  logic [IDW-1:0] grant_idx;
  logic           hi_any;
  logic [IDW-1:0] hi_idx;
  logic [IDW-1:0] lo_idx;
  logic           take;
  logic [OPW-1:0] sel_a;
  logic [OPW-1:0] sel_b;
  logic [PW-1:0]  prod;

  logic [IDW-1:0] ptr;
  logic           v1;
  logic [OPW-1:0] s1_a;
  logic [OPW-1:0] s1_b;
  logic [IDW-1:0] s1_id;

  assign adv  = !res_valid || res_ready;
  assign take = rst_n && adv && grant_any;

  // Lowest valid index at or above ptr wins; otherwise wrap to lowest valid overall.
  always_comb begin
    hi_any    = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    grant_any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_any = 1'b1;
        lo_idx    = IDW'(i);
        if (IDW'(i) >= ptr) begin
          hi_any = 1'b1;
          hi_idx = IDW'(i);
        end
      end
    end
    grant_idx = hi_any ? hi_idx : lo_idx;
  end

  // Accept strobe and operand select depend only on valids, ptr and adv.
  always_comb begin
    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    if (take) begin
      req_ready[grant_idx] = 1'b1;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == grant_idx) begin
        sel_a = req_a[OPW*i +: OPW];
        sel_b = req_b[OPW*i +: OPW];
      end
    end
  end

  // The single shared multiplier.
  assign prod = {{(PW-OPW){1'b0}}, s1_a} * {{(PW-OPW){1'b0}}, s1_b};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr         <= '0;
      v1          <= 1'b0;
      s1_a        <= '0;
      s1_b        <= '0;
      s1_id       <= '0;
      res_valid   <= 1'b0;
      res_product <= '0;
      res_id      <= '0;
      op_count    <= '0;
    end else begin
      if (adv) begin
        v1          <= take;
        s1_a        <= sel_a;
        s1_b        <= sel_b;
        s1_id       <= grant_idx;
        res_valid   <= v1;
        res_product <= prod;
        res_id      <= s1_id;
      end
      if (take) begin
        ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (res_valid && res_ready) begin
        op_count <= op_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mul_rr_sched.sv
// Self-checking bench for mul_rr_sched: vector table, hand sequences and a
// randomized run against a transaction-level reference model.
module tb_mul_rr_sched;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic [7:0]  res_product;
  logic [1:0]  res_id;
  logic        res_ready = 1'b0;
  logic [7:0]  op_count;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state: operands waiting for the multiplier, result on display.
  bit m1_v; int m1_a, m1_b, m1_id;
  bit m2_v; int m2_p, m2_id;
  int m_ptr, m_cnt, m_wraps;
  bit m_took;

  typedef struct {
    logic [3:0] v;
    logic       rr;
    logic [3:0] ready;
    logic       rv;
    int         id;
    int         prod;
    int         cnt;
  } vec_t;
  vec_t tbl[$];

  mul_rr_sched #(.NREQ(4), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .res_valid(res_valid), .res_product(res_product),
    .res_id(res_id), .res_ready(res_ready), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m1_v = 0; m1_a = 0; m1_b = 0; m1_id = 0;
    m2_v = 0; m2_p = 0; m2_id = 0;
    m_ptr = 0; m_cnt = 0; m_took = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle: compare DUT against model mid-cycle, then advance the model at the edge.
  task automatic model_cyc(input string tag);
    int g;
    bit adv;
    logic [3:0] er;
    @(negedge clk);
    adv = !m2_v || res_ready;
    g = rr_pick(req_valid, m_ptr);
    er = '0;
    if (adv && g >= 0) er[g] = 1'b1;
    check({tag, " req_ready"}, int'(req_ready), int'(er));
    check({tag, " res_valid"}, int'(res_valid), int'(m2_v));
    if (m2_v) begin
      check({tag, " res_product"}, int'(res_product), m2_p);
      check({tag, " res_id"}, int'(res_id), m2_id);
    end
    check({tag, " op_count"}, int'(op_count), m_cnt);
    @(posedge clk);
    m_took = 0;
    if (m2_v && res_ready) begin
      if (m_cnt == 255) m_wraps++;
      m_cnt = (m_cnt + 1) % 256;
    end
    if (adv) begin
      m2_v = m1_v; m2_p = m1_a * m1_b; m2_id = m1_id;
      m1_v = 0;
      if (g >= 0) begin
        m1_v = 1; m1_a = int'(req_a[4*g +: 4]); m1_b = int'(req_b[4*g +: 4]); m1_id = g;
        m_ptr = (g + 1) % N;
        m_took = 1;
      end
    end
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; req_valid = '0; res_ready = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int p, cyc, r;
    model_reset();
    m_wraps = 0;

    // Reset with every requester asserting.
    req_valid = 4'b1111; res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst req_ready", int'(req_ready), 0);
      if (i > 0) begin
        check("rst res_valid", int'(res_valid), 0);
        check("rst op_count", int'(op_count), 0);
      end
      tick();
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("first grant", int'(req_ready), 1);
    tick();

    // Vector table: fixed operands a=3+i, b=5.
    tbl.push_back('{4'b0100, 1'b1, 4'b0100, 1'b0, 0, 0, 0});
    tbl.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0, 0, 0, 0});
    tbl.push_back('{4'b0000, 1'b1, 4'b0000, 1'b1, 2, 25, 0});
    tbl.push_back('{4'b1111, 1'b1, 4'b1000, 1'b0, 0, 0, 1});
    tbl.push_back('{4'b1111, 1'b1, 4'b0001, 1'b0, 0, 0, 1});
    tbl.push_back('{4'b1111, 1'b1, 4'b0010, 1'b1, 3, 30, 1});
    for (int i = 0; i < 5; i++) tbl.push_back('{4'b1111, 1'b0, 4'b0000, 1'b1, 0, 15, 2});
    tbl.push_back('{4'b1111, 1'b1, 4'b0100, 1'b1, 0, 15, 2});
    tbl.push_back('{4'b0000, 1'b1, 4'b0000, 1'b1, 1, 20, 3});
    tbl.push_back('{4'b0000, 1'b1, 4'b0000, 1'b1, 2, 25, 4});
    tbl.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0, 0, 0, 5});
    do_reset(2);
    for (int i = 0; i < N; i++) begin
      req_a[4*i +: 4] = 4'(3 + i);
      req_b[4*i +: 4] = 4'd5;
    end
    foreach (tbl[i]) begin
      req_valid = tbl[i].v; res_ready = tbl[i].rr;
      @(negedge clk);
      check($sformatf("tbl%0d req_ready", i), int'(req_ready), int'(tbl[i].ready));
      check($sformatf("tbl%0d res_valid", i), int'(res_valid), int'(tbl[i].rv));
      if (tbl[i].rv) begin
        check($sformatf("tbl%0d res_id", i), int'(res_id), tbl[i].id);
        check($sformatf("tbl%0d res_product", i), int'(res_product), tbl[i].prod);
      end
      check($sformatf("tbl%0d op_count", i), int'(op_count), tbl[i].cnt);
      tick();
    end

    // Single 15*15 operation from requester 2.
    do_reset(1);
    res_ready = 1'b1; req_valid = 4'b0100;
    req_a[11:8] = 4'd15; req_b[11:8] = 4'd15;
    @(negedge clk); check("single ready", int'(req_ready), 4);
    tick(); req_valid = '0;
    @(negedge clk); check("single early valid", int'(res_valid), 0);
    tick();
    @(negedge clk);
    check("single valid", int'(res_valid), 1);
    check("single product", int'(res_product), 225);
    check("single id", int'(res_id), 2);
    tick();
    @(negedge clk);
    check("single op_count", int'(op_count), 1);
    check("single drained", int'(res_valid), 0);

    // Random traffic against the model.
    do_reset(1);
    for (int i = 0; i < 300; i++) begin
      req_valid = 4'($urandom);
      req_a = 16'($urandom); req_b = 16'($urandom);
      res_ready = ($urandom % 10) < 7;
      model_cyc("rand");
    end

    // Reset with both stages occupied.
    res_ready = 1'b1;
    req_valid = 4'b0001; model_cyc("fill0");
    req_valid = 4'b0010; model_cyc("fill1");
    check("fill s1 occupied", int'(m1_v), 1);
    rst_n = 1'b0; res_ready = 1'b0; req_valid = 4'b1111;
    @(negedge clk); check("midrst req_ready", int'(req_ready), 0);
    tick();
    rst_n = 1'b1; req_valid = '0; res_ready = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) model_cyc("midrst");

    // Every (A,B) pair through a random requester with random downstream stalls.
    do_reset(1);
    m_wraps = 0;
    p = 0; cyc = 0;
    while ((p < 256 || m1_v || m2_v) && cyc < 6000) begin
      req_valid = '0;
      req_a = 16'($urandom); req_b = 16'($urandom);
      if (p < 256 && ($urandom % 8) != 0) begin
        r = int'($urandom % N);
        req_valid[r] = 1'b1;
        req_a[4*r +: 4] = 4'(p >> 4);
        req_b[4*r +: 4] = 4'(p & 15);
      end
      res_ready = ($urandom % 4) != 0;
      model_cyc("exh");
      if (m_took) p++;
      cyc++;
    end
    check("exh pairs sent", p, 256);
    check("exh drained", int'(m1_v || m2_v), 0);
    check("exh wraps", m_wraps, 1);
    @(negedge clk);
    check("exh op_count", int'(op_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
